// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner: 2-flop sync, symmetric debounce, rising-edge press,
// single-depth request latch released by walk. Define PED_LOCKOUT_EN for post-walk dead time.
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int DB_W            = 4,
  parameter int LOCKOUT_CYCLES  = 32,
  parameter int LK_W            = 6,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             button_raw,
  input  logic             walk,
  output logic             ped_req,
  output logic             btn_clean,
  output logic [CNT_W-1:0] req_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2,
    LOCK  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic              clean_q, clean_d, clean_dly_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              press_s;
`ifdef PED_LOCKOUT_EN
  logic [LK_W-1:0]   lk_cnt_q, lk_cnt_d;
`else
  logic              unused_lk_s;
  assign unused_lk_s = ^{LOCKOUT_CYCLES[0], LK_W[0]};
`endif

  assign press_s = clean_q & ~clean_dly_q;

  // Debounce: clean level flips only after DEBOUNCE_CYCLES consecutive mismatching samples
  always_comb begin
    clean_d  = clean_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == clean_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      clean_d  = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Request FSM next state and saturating accepted-request counter
  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef PED_LOCKOUT_EN
    lk_cnt_d = lk_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (press_s) begin
          state_d = REQ;
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
          end else begin
            count_d = count_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (walk) begin
          state_d = SERVE;
        end else begin
          state_d = REQ;
        end
      end
      SERVE: begin
        if (!walk) begin
`ifdef PED_LOCKOUT_EN
          state_d  = LOCK;
          lk_cnt_d = '0;
`else
          state_d  = IDLE;
`endif
        end else begin
          state_d = SERVE;
        end
      end
`ifdef PED_LOCKOUT_EN
      LOCK: begin
        if (lk_cnt_q == LK_W'(LOCKOUT_CYCLES - 1)) begin
          state_d  = IDLE;
          lk_cnt_d = '0;
        end else begin
          state_d  = LOCK;
          lk_cnt_d = lk_cnt_q + LK_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      clean_q     <= 1'b0;
      clean_dly_q <= 1'b0;
      db_cnt_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
`ifdef PED_LOCKOUT_EN
      lk_cnt_q    <= '0;
`endif
    end else begin
      sync1_q     <= button_raw;
      sync2_q     <= sync1_q;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      db_cnt_q    <= db_cnt_d;
      count_q     <= count_d;
      state_q     <= state_d;
`ifdef PED_LOCKOUT_EN
      lk_cnt_q    <= lk_cnt_d;
`endif
    end
  end

  assign ped_req   = (state_q == REQ);
  assign btn_clean = clean_q;
  assign req_count = count_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Self-checking bench for ped_request_conditioner: directed scenarios with literal expectations,
// then randomized button/walk/reset traffic checked every cycle against a window-based model.
module tb_ped_request_conditioner;

  localparam int DB   = 4;
  localparam int LK   = 8;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          button_raw = 1'b0;
  logic          walk = 1'b0;
  logic          ped_req;
  logic          btn_clean;
  logic [CW-1:0] req_count;

  int n_cmp  = 0;
  int n_fail = 0;

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .DB_W           (2),
    .LOCKOUT_CYCLES (LK),
    .LK_W           (3),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button_raw(button_raw),
    .walk      (walk),
    .ped_req   (ped_req),
    .btn_clean (btn_clean),
    .req_count (req_count)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples since reset; the clean level flips when the DB most
  // recent synchronised samples (raw delayed two edges, zero before reset) all disagree with it.
  bit hist[$];
  bit m_clean = 1'b0;
  bit m_clean_old = 1'b0;
  bit m_valid = 1'b0;
  int m_mode = 0;        // 0 idle, 1 waiting for walk, 2 being served, 3 locked out
  int m_lock_left = 0;
  int m_count = 0;

  function automatic bit synced(int idx);
    return (idx >= 0) ? hist[idx] : 1'b0;
  endfunction

  task automatic model_step();
    bit press;
    bit flip;
    int n;
    if (!rst_n) begin
      hist.delete();
      m_clean = 1'b0;
      m_clean_old = 1'b0;
      m_mode = 0;
      m_count = 0;
      m_lock_left = 0;
    end else begin
      press = m_clean && !m_clean_old;
      case (m_mode)
        0: if (press) begin
             m_mode = 1;
             if (m_count < MAXC) m_count++;
           end
        1: if (walk) m_mode = 2;
        2: if (!walk) begin
`ifdef PED_LOCKOUT_EN
             m_mode = 3;
             m_lock_left = LK;
`else
             m_mode = 0;
`endif
           end
        3: begin
             m_lock_left--;
             if (m_lock_left == 0) m_mode = 0;
           end
        default: m_mode = 0;
      endcase
      hist.push_back(button_raw);
      if (hist.size() > 16) void'(hist.pop_front());
      n = hist.size();
      flip = 1'b1;
      for (int i = 0; i < DB; i++) begin
        if (synced(n - 3 - i) == m_clean) flip = 1'b0;
      end
      m_clean_old = m_clean;
      if (flip) m_clean = !m_clean;
    end
    m_valid = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic cmp(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      cmp("cyc_ped_req", int'(ped_req), int'(m_mode == 1));
      cmp("cyc_btn_clean", int'(btn_clean), int'(m_clean));
      cmp("cyc_req_count", int'(req_count), m_count);
    end
  end

  // Literal expectation checked against both the DUT and the model
  task automatic pin(string name, int dut_v, int mdl_v, int exp);
    cmp({name, "_dut"}, dut_v, exp);
    cmp({name, "_model"}, mdl_v, exp);
  endtask

  task automatic pin_all(string name, int e_req, int e_clean, int e_cnt);
    pin({name, "_ped_req"}, int'(ped_req), int'(m_mode == 1), e_req);
    pin({name, "_btn_clean"}, int'(btn_clean), int'(m_clean), e_clean);
    pin({name, "_req_count"}, int'(req_count), m_count, e_cnt);
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int raw_left;
    int walk_left;
    int exp_req;
    int exp_cnt;

    // Reset state
    tick(3);
    pin_all("reset", 0, 0, 0);
    rst_n = 1'b1;
    tick(3);

    // Clean press: edge k is the first to sample button_raw=1
    button_raw = 1'b1;
    tick(1);
    tick(4);
    pin_all("press_k4", 0, 0, 0);
    tick(1);
    pin_all("press_k5", 0, 1, 0);
    tick(1);
    pin_all("press_k6", 1, 1, 1);
    walk = 1'b1;
    tick(1);
    pin_all("walk_served", 0, 1, 1);
    walk = 1'b0;
    tick(12);
    pin_all("held_no_second", 0, 1, 1);
    button_raw = 1'b0;
    tick(6);
    pin_all("release", 0, 0, 1);

    // Bounce: 3 high, 2 low, 3 high, then low
    button_raw = 1'b1; tick(3);
    button_raw = 1'b0; tick(2);
    button_raw = 1'b1; tick(3);
    button_raw = 1'b0; tick(10);
    pin_all("bounce", 0, 0, 1);

    // Press debounced three edges after walk falls
    button_raw = 1'b1; tick(8);
    pin_all("req2", 1, 1, 2);
    button_raw = 1'b0; tick(6);
    walk = 1'b1; tick(1);
    button_raw = 1'b1; tick(2);
    walk = 1'b0; tick(1);
    tick(4);
`ifdef PED_LOCKOUT_EN
    exp_req = 0; exp_cnt = 2;
`else
    exp_req = 1; exp_cnt = 3;
`endif
    pin_all("post_walk_press", exp_req, 1, exp_cnt);

    // Re-press ends in REQ either way (absorbed when already pending)
    button_raw = 1'b0; tick(8);
    button_raw = 1'b1; tick(8);
    pin_all("req3", 1, 1, 3);

    // Reset mid-request with button held
    rst_n = 1'b0; tick(1);
    pin_all("mid_reset", 0, 0, 0);
    rst_n = 1'b1;
    tick(6);
    pin_all("rst_plus6", 0, 1, 0);
    tick(1);
    pin_all("rst_plus7", 1, 1, 1);

    // Saturation of the request counter
    walk = 1'b1; tick(1);
    walk = 1'b0; tick(1);
    button_raw = 1'b0; tick(8);
    for (int r = 0; r < 8; r++) begin
      button_raw = 1'b1; tick(8);
      pin_all("sat_req", 1, 1, (2 + r < MAXC) ? 2 + r : MAXC);
      walk = 1'b1; tick(1);
      walk = 1'b0; tick(1);
      button_raw = 1'b0; tick(8);
    end
    pin_all("saturated", 0, 0, MAXC);

    // Randomized traffic: bouncing button, independent walk, rare resets
    raw_left = 0;
    walk_left = 0;
    for (int c = 0; c < 6000; c++) begin
      if (raw_left == 0) begin
        button_raw = 1'($urandom_range(0, 1));
        raw_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(4, 16));
      end
      raw_left--;
      if (walk_left == 0) begin
        walk = 1'($urandom_range(0, 1));
        walk_left = int'($urandom_range(1, 20));
      end
      walk_left--;
      rst_n = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
